// File: rtl/egress_fifo_scheduler.sv
// Egress FIFO scheduler: round-robin arbitration over the per-port egress
// FIFOs that share one dpram. It pops a header word, issues a command to the
// SDRAM sequencer, then streams the write data or waits for the read burst to
// complete.
module egress_fifo_scheduler #(
  parameter int nr_of_wb_ports = 3
) (
  input  logic                      sdram_clk,
  input  logic                      sdram_rst,
  input  logic [nr_of_wb_ports-1:0] sdram_fifo_empty,
  output logic [nr_of_wb_ports-1:0] sdram_fifo_rd,
  output logic [2:0]                fifo_sel_o,
  input  logic [35:0]               sdram_dat_i,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [29:0]               cmd_adr_o,
  output logic                      cmd_we_o,
  output logic [4:0]                cmd_len_o,
  input  logic                      wdat_ready_i,
  output logic                      wdat_valid_o,
  output logic [35:0]               wdat_o,
  input  logic                      rd_done_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR_POP = 3'd1;
  localparam logic [2:0] S_HDR_CAP = 3'd2;
  localparam logic [2:0] S_CMD     = 3'd3;
  localparam logic [2:0] S_WDATA   = 3'd4;
  localparam logic [2:0] S_RWAIT   = 3'd5;

  localparam logic [3:0] NR_PORTS  = 4'(nr_of_wb_ports);
  // Port nr_of_wb_ports-1 counts as the previous winner so port 0 goes first.
  localparam logic [2:0] LAST_INIT = 3'(nr_of_wb_ports - 1);

  // Burst length from the Wishbone CTI/BTE fields of a header word.
  function automatic logic [4:0] burst_len(input logic [2:0] cti, input logic [1:0] bte);
    logic [4:0] len;
    len = 5'd1;
    case (cti)
      3'b010: begin
        case (bte)
          2'b01:   len = 5'd4;
          2'b10:   len = 5'd8;
          2'b11:   len = 5'd16;
          default: len = 5'd1;
        endcase
      end
      default: len = 5'd1;
    endcase
    return len;
  endfunction

  logic [2:0]  r_state;
  logic [2:0]  r_grant;
  logic [2:0]  r_last_grant;
  logic [29:0] r_adr;
  logic        r_we;
  logic [4:0]  r_len;
  logic [4:0]  r_beats;
  logic        r_wvalid;

  logic [7:0]  w_empty8;
  logic [7:0]  w_rd8;
  logic        w_found;
  logic        w_hit;
  logic [2:0]  w_next_grant;
  logic [3:0]  w_idx;
  logic [3:0]  w_wrap;
  logic        w_data_pop;
  logic        w_pop;

  // Round-robin search for the first non-empty FIFO after the previous winner.
  always_comb begin
    w_empty8                         = 8'hFF;
    w_empty8[nr_of_wb_ports-1:0]     = sdram_fifo_empty;
    w_found                          = 1'b0;
    w_hit                            = 1'b0;
    w_next_grant                     = 3'd0;
    w_idx                            = 4'd0;
    w_wrap                           = 4'd0;
    for (int k = 1; k <= nr_of_wb_ports; k++) begin
      w_idx        = {1'b0, r_last_grant} + 4'(k);
      w_wrap       = (w_idx >= NR_PORTS) ? (w_idx - NR_PORTS) : w_idx;
      w_hit        = !w_found && !w_empty8[w_wrap[2:0]];
      w_next_grant = w_hit ? w_wrap[2:0] : w_next_grant;
      w_found      = w_found | w_hit;
    end
  end

  // Pop strobe: the header pop, or a data pop when the sink is ready and the
  // granted FIFO has a word; the strobe only ever targets the granted FIFO.
  always_comb begin
    w_data_pop = (r_state == S_WDATA) && wdat_ready_i &&
                 !w_empty8[r_grant] && (r_beats != 5'd0);
    w_pop      = (r_state == S_HDR_POP) || w_data_pop;
    if (w_pop) begin
      w_rd8 = 8'd1 << r_grant;
    end else begin
      w_rd8 = 8'd0;
    end
  end

  assign sdram_fifo_rd = w_rd8[nr_of_wb_ports-1:0];
  assign fifo_sel_o    = r_grant;
  assign cmd_valid_o   = (r_state == S_CMD);
  assign cmd_adr_o     = r_adr;
  assign cmd_we_o      = r_we;
  assign cmd_len_o     = r_len;
  assign wdat_valid_o  = r_wvalid;
  // The dpram word is valid the cycle after its pop, which is exactly when
  // r_wvalid is high; it is masked to zero otherwise.
  assign wdat_o        = r_wvalid ? sdram_dat_i : 36'd0;

  // Scheduler state machine, captured header fields and beat counter.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 3'd0;
      r_last_grant <= LAST_INIT;
      r_adr        <= 30'd0;
      r_we         <= 1'b0;
      r_len        <= 5'd0;
      r_beats      <= 5'd0;
      r_wvalid     <= 1'b0;
    end else begin
      r_wvalid <= w_data_pop;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant      <= w_next_grant;
            r_last_grant <= w_next_grant;
            r_state      <= S_HDR_POP;
          end
        end
        S_HDR_POP: begin
          r_state <= S_HDR_CAP;
        end
        S_HDR_CAP: begin
          r_adr   <= sdram_dat_i[35:6];
          r_we    <= sdram_dat_i[5];
          r_len   <= burst_len(sdram_dat_i[2:0], sdram_dat_i[4:3]);
          r_state <= S_CMD;
        end
        S_CMD: begin
          if (cmd_ready_i) begin
            r_beats <= r_len;
            r_state <= r_we ? S_WDATA : S_RWAIT;
          end
        end
        S_WDATA: begin
          if (w_data_pop) begin
            r_beats <= r_beats - 5'd1;
            if (r_beats == 5'd1) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_RWAIT: begin
          if (rd_done_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/egress_fifo_scheduler.md
EGRESS_FIFO_SCHEDULER -- requirements
Module: egress_fifo_scheduler

Interface
REQ-001 SHALL have parameter nr_of_wb_ports, default 3, legal 1..8: number of per-port egress FIFOs sharing one egress dpram.
REQ-002 SHALL have port sdram_clk  input  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port sdram_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port sdram_fifo_empty  input  nr_of_wb_ports  bit i high = egress FIFO i empty.
REQ-005 SHALL have port sdram_fifo_rd  output  nr_of_wb_ports  one-hot pop strobe to FIFO i read counter.
REQ-006 SHALL have port fifo_sel_o  output  3  binary index of granted FIFO, upper dpram read address.
REQ-007 SHALL have port sdram_dat_i  input  36  dpram word, valid the cycle after the pop.
REQ-008 SHALL have ports cmd_valid_o output 1, cmd_ready_i input 1, cmd_adr_o output 30, cmd_we_o output 1, cmd_len_o output 5: command handshake to the SDRAM sequencer.
REQ-009 SHALL have ports wdat_ready_i input 1, wdat_valid_o output 1, wdat_o output 36 ({sel[3:0],data[31:0]}): write-data stream.
REQ-010 SHALL have port rd_done_i  input  1  one-cycle pulse when the sequencer finishes a read burst.

Function
REQ-011 Header word format SHALL be [35:6] address, [5] WE, [4:3] BTE, [2:0] CTI.
REQ-012 Burst length SHALL be: CTI 000 or 111 -> 1; CTI 010 with BTE wrap4/wrap8/wrap16 -> 4/8/16; CTI 010 with BTE linear -> 1; any other CTI -> 1.
REQ-013 States SHALL be IDLE, HDR_POP, HDR_CAP, CMD, WDATA, RWAIT.
REQ-014 IDLE: if any sdram_fifo_empty bit low, grant the first non-empty FIFO searching round-robin from (last_grant+1) mod nr_of_wb_ports, -> HDR_POP same cycle the grant registers.
REQ-015 HDR_POP SHALL assert sdram_fifo_rd[grant] for exactly one cycle, -> HDR_CAP.
REQ-016 HDR_CAP SHALL register address, WE, length from sdram_dat_i, -> CMD.
REQ-017 CMD SHALL hold cmd_valid_o high with stable cmd_adr_o/cmd_we_o/cmd_len_o until cmd_ready_i sampled high; then -> WDATA if WE, else -> RWAIT.
REQ-018 WDATA SHALL pop one word when wdat_ready_i high and sdram_fifo_empty[grant] low; wdat_valid_o high exactly the following cycle with wdat_o = sdram_dat_i.
REQ-019 Downstream SHALL accept every wdat_valid_o beat; wdat_ready_i gates only pops.
REQ-020 Beat counter SHALL load length at CMD acceptance, decrement per pop; after last pop -> IDLE (final wdat_valid_o occurs in IDLE cycle).
REQ-021 Empty granted FIFO in WDATA SHALL stall without pop; grant SHALL NOT change mid-burst.
REQ-022 RWAIT SHALL wait for rd_done_i then -> IDLE; rd_done_i outside RWAIT ignored.
REQ-023 last_grant SHALL update on entry to HDR_POP.
REQ-024 At most one sdram_fifo_rd bit SHALL be high per cycle; none outside HDR_POP/WDATA.
REQ-025 fifo_sel_o SHALL equal grant index from HDR_POP until return to IDLE, and hold last value in IDLE.

Reset
REQ-026 sdram_rst high at any edge, including mid-burst, SHALL force IDLE next cycle with sdram_fifo_rd=0, cmd_valid_o=0, wdat_valid_o=0, fifo_sel_o=0, cmd_adr_o=0, cmd_we_o=0, cmd_len_o=0, wdat_o=0, beat counter 0.
REQ-027 After reset last_grant SHALL be nr_of_wb_ports-1 so port 0 wins first.

Verification
REQ-028 All FIFOs non-empty, single writes CTI=000 each, cmd_ready_i=1 -> grants in order 0,1,2,0; each command cmd_len_o=1.
REQ-029 Port 1 header adr=0x0000100, WE=1, CTI=010, BTE=wrap4, wdat_ready_i toggling 1/0 -> cmd_len_o=4, exactly 4 pops, 4 wdat_valid_o beats each one cycle after its pop.
REQ-030 Port 2 read header WE=0, cmd_ready_i delayed 3 cycles -> cmd_valid_o stable 4 cycles; grant held until rd_done_i; spurious rd_done_i in IDLE no effect.
REQ-031 Wrap16 write with sdram_fifo_empty[grant]=1 for 5 cycles after beat 7 -> no pops during stall, 16 total beats, no other port granted.
REQ-032 sdram_rst asserted at beat 2 of wrap8 write -> next cycle all outputs 0, state IDLE, next grant port 0.
